wb_slave_decoder: RTL and testbench
===================================

// Module: wb_slave_decoder
// PURPOSE
//  Slave-side companion of the four-master round-robin arbiter: decodes the granted
//  master's address onto one of four Wishbone slaves. It drives the per-slave STB and
//  returns ACK/ERR. The slave select is latched for the whole CYC tenure.
//  A watchdog terminates hung cycles with ERR. Sits between the arbiter's master mux
//  and the slave ports of the shared bus.
// PARAMETERS
//  AW       32            address width
//  DEC_MSB  31            msb of decoded address field
//  DEC_LSB  28            lsb of decoded field; FW = DEC_MSB-DEC_LSB+1
//  S0_BASE  4'h0          field value selecting slave 0 (width FW)
//  S1_BASE  4'h1          field value selecting slave 1
//  S2_BASE  4'h2          field value selecting slave 2
//  S3_BASE  4'h3          field value selecting slave 3
//  TIMEOUT  16            cycles of STB without ACK/ERR before forced ERR (>=2)
//  TW       5             watchdog counter width; must hold TIMEOUT
// PORTS
//  CLK      in   1    bus clock; everything is rising-edge synchronous
//  RST      in   1    synchronous, active-high reset
//  CYC      in   1    muxed master CYC (from arbiter-selected master)
//  STB      in   1    muxed master STB
//  ADR      in   AW   muxed master address
//  ACK_I    in   4    per-slave ACK, bit n = slave n
//  ERR_I    in   4    per-slave ERR
//  STB_O    out  4    per-slave STB, one-hot or zero
//  ACK      out  1    ACK returned to master mux
//  ERR      out  1    ERR returned to master mux (slave ERR, decode miss or timeout)
//  SSEL     out  2    latched slave index
//  BUSY     out  1    high while state != IDLE
//  TOUT     out  1    one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset: state=IDLE, SSEL=0, all STB_O=0, ACK=0, ERR=0, TOUT=0, watchdog=0.
//    RST mid-transfer aborts immediately; no ACK/ERR is produced for the aborted cycle.
//  States: IDLE, ACTIVE, FAULT, HOLD.
//  IDLE: STB_O=0, ACK=0. On CYC&STB, decode ADR[DEC_MSB:DEC_LSB]:
//    - match Sn  -> SSEL<=n, go to ACTIVE. Lowest n wins if bases collide.
//    - no match  -> go to FAULT.
//    Decode latency: 1 cycle. STB_O appears the cycle after CYC&STB is first seen.
//  ACTIVE: STB_O[SSEL]=STB, other bits 0.
//    ACK=ACK_I[SSEL]&STB and ERR=ERR_I[SSEL]&STB, combinational. Other slaves' ACK/ERR are ignored.
//    Watchdog increments each cycle STB=1 with no ACK/ERR from the selected slave.
//    It clears on ACK, on ERR, or when STB=0.
//    When the count reaches TIMEOUT-1 and STB is still high: go to FAULT, pulse TOUT.
//    CYC=0 -> IDLE next cycle, regardless of STB.
//    Back-to-back STBs within one CYC stay on SSEL. The address is not re-decoded.
//  FAULT: STB_O=0, ERR=1 for exactly one cycle, ACK=0, then go to HOLD.
//  HOLD: STB_O=0, ACK=0, ERR=0 until CYC=0, then go to IDLE.
//    A master that keeps CYC high after ERR receives no further responses.
//  Simultaneous events:
//    - ACK_I[SSEL] on the same cycle the watchdog would fire: ACK wins, no TOUT, counter clears.
//    - ACK_I and ERR_I from the selected slave together: both forwarded; the master treats it as ERR.
//    - CYC drop in FAULT: ERR still pulses, then go to IDLE (skip HOLD).
//  Watchdog counter saturates, never wraps. SSEL holds its last value in IDLE.
// STRUCTURE
//  Package wb_dec_pkg: state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, FAULT=2'd2,
//    HOLD=2'd3), NSLV=4, and the decode function returning {hit,index}.
//  Sub-module wb_watchdog (TW, TIMEOUT): inputs CLK, RST, run, clr; output expire.
//    The top level holds the FSM, latched SSEL and the STB_O/ACK/ERR muxes.
// TESTING
//  1 ADR=32'h2000_0010, CYC=STB=1; slave 2 ACKs 3 cycles later ->
//    STB_O=4'b0100 from cycle 1, ACK=1 in the same cycle as ACK_I[2], SSEL=2, BUSY=1.
//  2 ADR=32'h9000_0000 (no base) -> ERR=1 for one cycle at cycle 1,
//    STB_O=0 throughout, HOLD until CYC=0, then IDLE.
//  3 Slave 1 never ACKs, TIMEOUT=16 -> TOUT and ERR pulse once, STB_O[1] falls;
//    ACK_I[1] arriving later is not forwarded.
//  4 Slave 0 ACKs on the exact cycle of expiry -> ACK=1, ERR=0, TOUT=0.
//    Slave 3 ERR_I -> ERR forwarded same cycle.
//  5 Four STBs in one CYC to slave 3 with ADR changed to 32'h0... after the first ->
//    all four go to STB_O[3]; CYC=0 -> IDLE next cycle.
//  6 RST asserted in ACTIVE with STB high -> next cycle all outputs 0,
//    state IDLE, watchdog 0.

Source files
------------

// File: rtl/wb_dec_pkg.sv
// Shared encodings and the address-field decoder for the Wishbone slave decoder.
package wb_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAULT  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int NSLV = 4;

    // Returns {hit, index}. Checked from slave 3 down so the lowest index wins on collisions.
    function automatic logic [2:0] dec_slave(input logic [31:0] fld,
                                             input logic [31:0] b0,
                                             input logic [31:0] b1,
                                             input logic [31:0] b2,
                                             input logic [31:0] b3);
        logic [2:0] r;
        r = 3'b000;
        if (fld == b3) r = {1'b1, 2'd3};
        if (fld == b2) r = {1'b1, 2'd2};
        if (fld == b1) r = {1'b1, 2'd1};
        if (fld == b0) r = {1'b1, 2'd0};
        return r;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Saturating stall counter; expire fires on the run cycle that completes TIMEOUT stalled cycles.
module wb_watchdog #(
    parameter int TW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr)
            cnt <= '0;
        else if (run && cnt != '1)
            cnt <= cnt + TW'(1);
    end

    assign expire = run && (cnt == LAST);

endmodule

// File: rtl/wb_slave_decoder.sv
// Routes the granted master onto one of four Wishbone slaves, latching the select per CYC.
module wb_slave_decoder
    import wb_dec_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DEC_MSB = 31,
    parameter int DEC_LSB = 28,
    parameter logic [DEC_MSB-DEC_LSB:0] S0_BASE = 4'h0,
    parameter logic [DEC_MSB-DEC_LSB:0] S1_BASE = 4'h1,
    parameter logic [DEC_MSB-DEC_LSB:0] S2_BASE = 4'h2,
    parameter logic [DEC_MSB-DEC_LSB:0] S3_BASE = 4'h3,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CYC,
    input  logic            STB,
    input  logic [AW-1:0]   ADR,
    input  logic [NSLV-1:0] ACK_I,
    input  logic [NSLV-1:0] ERR_I,
    output logic [NSLV-1:0] STB_O,
    output logic            ACK,
    output logic            ERR,
    output logic [1:0]      SSEL,
    output logic            BUSY,
    output logic            TOUT
);

    state_t          state, state_n;
    logic [1:0]      ssel_q, ssel_n;
    logic [2:0]      dec;
    logic            run, expire;
    logic [NSLV-1:0] stb_o;
    logic            ack, err, tout;
    logic            unused_adr;

    assign unused_adr = ^ADR;

    assign dec = dec_slave(32'(ADR[DEC_MSB:DEC_LSB]), 32'(S0_BASE), 32'(S1_BASE),
                           32'(S2_BASE), 32'(S3_BASE));

    // A CYC drop outranks expiry so a released bus never sees a stray ERR.
    assign run = (state == ACTIVE) && CYC && STB && !ACK_I[ssel_q] && !ERR_I[ssel_q];

    wb_watchdog #(.TW(TW), .TIMEOUT(TIMEOUT)) u_wdog (
        .CLK    (CLK),
        .RST    (RST),
        .run    (run),
        .clr    (!run),
        .expire (expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ssel_q <= 2'd0;
        end else begin
            state  <= state_n;
            ssel_q <= ssel_n;
        end
    end

    always_comb begin
        state_n = state;
        ssel_n  = ssel_q;
        stb_o   = '0;
        ack     = 1'b0;
        err     = 1'b0;
        tout    = 1'b0;
        case (state)
            IDLE: begin
                if (CYC && STB) begin
                    if (dec[2]) begin
                        ssel_n  = dec[1:0];
                        state_n = ACTIVE;
                    end else begin
                        state_n = FAULT;
                    end
                end
            end
            ACTIVE: begin
                stb_o[ssel_q] = STB;
                ack           = ACK_I[ssel_q] && STB;
                err           = ERR_I[ssel_q] && STB;
                if (!CYC) begin
                    state_n = IDLE;
                end else if (expire) begin
                    tout    = 1'b1;
                    state_n = FAULT;
                end
            end
            FAULT: begin
                err     = 1'b1;
                state_n = CYC ? HOLD : IDLE;
            end
            HOLD: begin
                if (!CYC) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign STB_O = stb_o;
    assign ACK   = ack;
    assign ERR   = err;
    assign TOUT  = tout;
    assign SSEL  = ssel_q;
    assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Directed scoreboard bench: each driven cycle queues its expected outputs; a negedge monitor checks them.
module tb_wb_slave_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CYC = 1'b0;
    logic        STB = 1'b0;
    logic [31:0] ADR = '0;
    logic [3:0]  ACK_I = '0;
    logic [3:0]  ERR_I = '0;
    logic [3:0]  STB_O;
    logic        ACK, ERR, BUSY, TOUT;
    logic [1:0]  SSEL;

    wb_slave_decoder dut (
        .CLK   (CLK),
        .RST   (RST),
        .CYC   (CYC),
        .STB   (STB),
        .ADR   (ADR),
        .ACK_I (ACK_I),
        .ERR_I (ERR_I),
        .STB_O (STB_O),
        .ACK   (ACK),
        .ERR   (ERR),
        .SSEL  (SSEL),
        .BUSY  (BUSY),
        .TOUT  (TOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] stbo;
        logic       ack;
        logic       err;
        logic [1:0] ssel;
        logic       busy;
        logic       tout;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    localparam logic [31:0] A0 = 32'h0000_0000;
    localparam logic [31:0] A1 = 32'h1000_0000;
    localparam logic [31:0] A2 = 32'h2000_0010;
    localparam logic [31:0] A3 = 32'h3000_0000;
    localparam logic [31:0] AX = 32'h9000_0000;

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if ({STB_O, ACK, ERR, SSEL, BUSY, TOUT} !==
                {mon_e.stbo, mon_e.ack, mon_e.err, mon_e.ssel, mon_e.busy, mon_e.tout})
                $display("FAIL %s: got stbo=%b ack=%b err=%b ssel=%0d busy=%b tout=%b, want stbo=%b ack=%b err=%b ssel=%0d busy=%b tout=%b",
                         mon_e.name, STB_O, ACK, ERR, SSEL, BUSY, TOUT,
                         mon_e.stbo, mon_e.ack, mon_e.err, mon_e.ssel, mon_e.busy, mon_e.tout);
            else
                passed++;
        end
    end

    task automatic step(input logic r, input logic c, input logic s, input logic [31:0] a,
                        input logic [3:0] ak, input logic [3:0] er,
                        input logic [3:0] e_stbo, input logic e_ack, input logic e_err,
                        input logic [1:0] e_ssel, input logic e_busy, input logic e_tout,
                        input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        RST = r; CYC = c; STB = s; ADR = a; ACK_I = ak; ERR_I = er;
        e.stbo = e_stbo; e.ack = e_ack; e.err = e_err;
        e.ssel = e_ssel; e.busy = e_busy; e.tout = e_tout; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        step(1, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "reset");

        // 1: slave 2 ACK three cycles after decode
        step(0, 1, 1, A2, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "t1_req");
        step(0, 1, 1, A2, 0, 0, 4'b0100, 0, 0, 2, 1, 0, "t1_stb1");
        step(0, 1, 1, A2, 0, 0, 4'b0100, 0, 0, 2, 1, 0, "t1_stb2");
        step(0, 1, 1, A2, 4'b0100, 0, 4'b0100, 1, 0, 2, 1, 0, "t1_ack");
        step(0, 0, 0, A2, 0, 0, 4'b0000, 0, 0, 2, 1, 0, "t1_cyc_drop");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 2, 0, 0, "t1_idle");

        // 2: decode miss -> single ERR, HOLD until CYC drops
        step(0, 1, 1, AX, 0, 0, 4'b0000, 0, 0, 2, 0, 0, "t2_req");
        step(0, 1, 1, AX, 0, 0, 4'b0000, 0, 1, 2, 1, 0, "t2_fault");
        step(0, 1, 1, AX, 0, 0, 4'b0000, 0, 0, 2, 1, 0, "t2_hold1");
        step(0, 1, 0, AX, 4'b0100, 4'b0100, 4'b0000, 0, 0, 2, 1, 0, "t2_hold2");
        step(0, 0, 0, AX, 0, 0, 4'b0000, 0, 0, 2, 1, 0, "t2_hold_exit");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 2, 0, 0, "t2_idle");

        // 3: slave 1 hangs -> watchdog fires on the 16th stalled cycle
        step(0, 1, 1, A1, 0, 0, 4'b0000, 0, 0, 2, 0, 0, "t3_req");
        for (int k = 1; k <= 16; k++)
            step(0, 1, 1, A1, 0, 0, 4'b0010, 0, 0, 1, 1, (k == 16), "t3_wait");
        step(0, 1, 1, A1, 0, 0, 4'b0000, 0, 1, 1, 1, 0, "t3_fault");
        step(0, 1, 1, A1, 4'b0010, 0, 4'b0000, 0, 0, 1, 1, 0, "t3_late_ack");
        step(0, 0, 0, A1, 0, 0, 4'b0000, 0, 0, 1, 1, 0, "t3_hold_exit");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, "t3_idle");

        // 4a: slave 0 ACKs on the expiry cycle
        step(0, 1, 1, A0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, "t4_req");
        for (int k = 1; k <= 15; k++)
            step(0, 1, 1, A0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, "t4_wait");
        step(0, 1, 1, A0, 4'b0001, 0, 4'b0001, 1, 0, 0, 1, 0, "t4_ack_at_expiry");
        step(0, 1, 1, A0, 0, 0, 4'b0001, 0, 0, 0, 1, 0, "t4_wdog_cleared");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, "t4_cyc_drop");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "t4_idle");

        // 4b: slave 3 ERR forwarded; other slaves ignored; ACK+ERR both forwarded
        step(0, 1, 1, A3, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "t4b_req");
        step(0, 1, 1, A3, 4'b0001, 4'b1001, 4'b1000, 0, 1, 3, 1, 0, "t4b_err");
        step(0, 1, 1, A3, 4'b1000, 4'b1000, 4'b1000, 1, 1, 3, 1, 0, "t4b_ack_err");
        step(0, 0, 0, A3, 0, 0, 4'b0000, 0, 0, 3, 1, 0, "t4b_cyc_drop");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 3, 0, 0, "t4b_idle");

        // 5: four STBs in one CYC, address changed after the first
        step(0, 1, 1, A3, 0, 0, 4'b0000, 0, 0, 3, 0, 0, "t5_req");
        step(0, 1, 1, A0, 4'b1000, 0, 4'b1000, 1, 0, 3, 1, 0, "t5_stb1");
        step(0, 1, 0, A0, 0, 0, 4'b0000, 0, 0, 3, 1, 0, "t5_gap");
        step(0, 1, 1, A0, 4'b1000, 0, 4'b1000, 1, 0, 3, 1, 0, "t5_stb2");
        step(0, 1, 1, A1, 4'b1000, 0, 4'b1000, 1, 0, 3, 1, 0, "t5_stb3");
        step(0, 1, 1, A2, 4'b1000, 0, 4'b1000, 1, 0, 3, 1, 0, "t5_stb4");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 3, 1, 0, "t5_cyc_drop");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 3, 0, 0, "t5_idle");

        // 6: reset in ACTIVE, then a full watchdog run proves the counter restarted at 0
        step(0, 1, 1, A1, 0, 0, 4'b0000, 0, 0, 3, 0, 0, "t6_req");
        step(0, 1, 1, A1, 0, 0, 4'b0010, 0, 0, 1, 1, 0, "t6_stb1");
        step(0, 1, 1, A1, 0, 0, 4'b0010, 0, 0, 1, 1, 0, "t6_stb2");
        step(1, 1, 1, A1, 0, 0, 4'b0010, 0, 0, 1, 1, 0, "t6_rst_cycle");
        step(0, 1, 1, A1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "t6_after_rst");
        for (int k = 1; k <= 16; k++)
            step(0, 1, 1, A1, 0, 0, 4'b0010, 0, 0, 1, 1, (k == 16), "t6_wait");
        // CYC drops while in FAULT: ERR still pulses, HOLD is skipped
        step(0, 0, 0, A1, 0, 0, 4'b0000, 0, 1, 1, 1, 0, "t6_fault_cyc_drop");
        step(0, 0, 0, A0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, "t6_idle");

        repeat (3) @(posedge CLK);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
